seq_shift_unit: RTL
===================

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits; legal values are 2 or more.
REQ-002 SHALL have parameter AMT_W, default 3: Amount width; it SHALL equal clog2(WIDTH).
REQ-003 SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port Start, input, 1 bit: request a new operation; sampled only while Busy=0.
REQ-006 SHALL have port LRSelect, input, 1 bit: shift direction; 0=left, 1=right.
REQ-007 SHALL have port Mode, input, 2 bits: 00=logical, 01=arithmetic, 10=rotate; 11 is reserved and behaves as 00.
REQ-008 SHALL have port Amount, input, AMT_W bits: number of bit positions to shift, 0..WIDTH-1.
REQ-009 SHALL have port ShifterInput, input, WIDTH bits: operand.
REQ-010 SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 SHALL have port ShifterOutput, output, WIDTH bits: registered result.
REQ-013 SHALL have port Shift_Out_Bit, output, 1 bit: the last bit shifted or rotated out.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, Start=1 SHALL latch ShifterInput into the working register, latch LRSelect, Mode and Amount, and clear Shift_Out_Bit.
REQ-016 After latching, the next state SHALL be SHIFT if the latched Amount is nonzero, otherwise DONE.
REQ-017 Each Clock edge in SHIFT SHALL perform exactly one 1-bit step and decrement the remaining count; the step taken from SHIFT with count 1 SHALL go to DONE.
REQ-018 Logical left: out=bit[WIDTH-1]; bit[i]<=bit[i-1]; bit[0]<=0.
REQ-019 Logical right: out=bit[0]; bit[i]<=bit[i+1]; bit[WIDTH-1]<=0.
REQ-020 Arithmetic right SHALL behave as logical right except bit[WIDTH-1] keeps its value (sign fill); arithmetic left SHALL equal logical left.
REQ-021 Rotate SHALL wrap the outgoing bit into the vacated end (bit[0] for left, bit[WIDTH-1] for right) and also drive it onto Shift_Out_Bit.
REQ-022 Shift_Out_Bit SHALL update on every step and hold its value otherwise; with Amount=0 it SHALL be 0.
REQ-023 Latency: with Start sampled at edge t0, Done SHALL be 1 for exactly the cycle following edge t0+max(Amount,1).
REQ-024 ShifterOutput SHALL hold the final result until the next accepted Start.
REQ-025 Busy SHALL be 1 in SHIFT only; it SHALL be 0 in IDLE and in DONE.
REQ-026 Start=1 while Busy=1 SHALL be ignored, with no effect on state, result or count.
REQ-027 Start in the DONE cycle SHALL be accepted, allowing back-to-back operations with Done still pulsing for the prior operation.
REQ-028 DONE without Start SHALL return to IDLE on the next edge.
REQ-029 Inputs other than Start SHALL be don't-care outside the Start-acceptance cycle; changing them mid-operation SHALL NOT affect the result.

Reset
REQ-030 Reset=1 SHALL immediately, independent of Clock, force state IDLE, ShifterOutput=0, Shift_Out_Bit=0, Busy=0, Done=0 and count=0.
REQ-031 Reset asserted mid-SHIFT SHALL abort the operation with no Done pulse, and no operation SHALL resume after release.
REQ-032 The first Start SHALL be accepted on the first Clock edge after Reset deasserts.

Verification (WIDTH=8)
REQ-033 Logical left, Amount=1, input 0x96 -> output 0x2C, Shift_Out_Bit=1, Done at t0+1.
REQ-034 Logical right, Amount=3, input 0x96 -> output 0x12, Shift_Out_Bit=1, Busy high for 3 cycles, Done at t0+3.
REQ-035 Arithmetic right, Amount=2, input 0x96 -> output 0xE5, Shift_Out_Bit=1; rotate right, Amount=4, input 0x96 -> output 0x69, Shift_Out_Bit=0; rotate left, Amount=3, input 0x96 -> output 0xB4, Shift_Out_Bit=0.
REQ-036 Amount=0, input 0x5A -> output 0x5A, Shift_Out_Bit=0, Done at t0+1, Busy never 1.
REQ-037 Start re-pulsed during SHIFT with a different input -> ignored, original result produced; Start in the DONE cycle -> new operation starts immediately.
REQ-038 Reset asserted at t0+2 of an Amount=5 operation -> all outputs 0 asynchronously, no Done pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, logical/arithmetic/rotate, left or right.
// Latency: Done pulses in the cycle after edge t0+max(Amount,1); Start is ignored while Busy.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             LRSelect,
    input  logic [1:0]       Mode,
    input  logic [AMT_W-1:0] Amount,
    input  logic [WIDTH-1:0] ShifterInput,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ShifterOutput,
    output logic             Shift_Out_Bit
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_LOG   = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             dir_q,     dir_d;
    logic [1:0]       mode_q,    mode_d;
    logic [AMT_W-1:0] cnt_q,     cnt_d;
    logic             out_bit_q, out_bit_d;
    logic             done_q,    done_d;
    logic             zero_q,    zero_d;

    logic [WIDTH-1:0] step_dat;
    logic             step_bit;
    logic             accept;

    // Single 1-bit step of the working register in the latched direction/mode.
    always_comb begin
        step_dat = data_q;
        step_bit = 1'b0;
        if (!dir_q) begin
            step_bit = data_q[WIDTH-1];
            step_dat = {data_q[WIDTH-2:0], 1'b0};
            if (mode_q == MODE_ROT) begin
                step_dat[0] = data_q[WIDTH-1];
            end
        end else begin
            step_bit = data_q[0];
            step_dat = {1'b0, data_q[WIDTH-1:1]};
            if (mode_q == MODE_ROT) begin
                step_dat[WIDTH-1] = data_q[0];
            end else if (mode_q == MODE_ARITH) begin
                step_dat[WIDTH-1] = data_q[WIDTH-1];
            end
        end
    end

    assign accept = Start && (state_q != ST_SHIFT);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        out_bit_d = out_bit_q;
        zero_d    = zero_q;
        done_d    = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                data_d    = step_dat;
                out_bit_d = step_bit;
                cnt_d     = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                // A zero-amount operation reaches DONE one edge early, so its pulse is delayed here.
                done_d  = zero_q;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            data_d    = ShifterInput;
            dir_d     = LRSelect;
            mode_d    = (Mode == 2'b11) ? MODE_LOG : Mode;
            cnt_d     = Amount;
            zero_d    = (Amount == '0);
            out_bit_d = 1'b0;
            state_d   = (Amount != '0) ? ST_SHIFT : ST_DONE;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            dir_q     <= 1'b0;
            mode_q    <= MODE_LOG;
            cnt_q     <= '0;
            out_bit_q <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            out_bit_q <= out_bit_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign Busy          = (state_q == ST_SHIFT);
    assign Done          = done_q;
    assign ShifterOutput = data_q;
    assign Shift_Out_Bit = out_bit_q;

endmodule
